// File: rtl/crc_err_rsp_fifo.sv
// Error-response queue between the CRC engine and the register wrapper.
// Shows one entry at a time in the ERR_FIFO registers; each firmware POP rising edge advances it.
module crc_err_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_arst,
    input  logic             i_push,
    input  logic [7:0]       i_err_rsp_code,
    input  logic [63:0]      i_poly,
    input  logic [31:0]      i_data_addr,
    input  logic [31:0]      i_crc_addr,
    input  logic [1:0]       i_poly_size_sel,
    input  logic [2:0]       i_rpt_num,
    input  logic [15:0]      i_req_id,
    input  logic             i_pop,
    output logic [7:0]       o_crc_err_fifo_pop_err_rsp_code_next,
    output logic [31:0]      o_crc_err_fifo_data0_poly_lsb_next,
    output logic [31:0]      o_crc_err_fifo_data1_poly_msb_next,
    output logic [31:0]      o_crc_err_fifo_data2_data_addr_next,
    output logic [31:0]      o_crc_err_fifo_data3_crc_addr_next,
    output logic [1:0]       o_crc_err_fifo_data4_crc_poly_size_sel_next,
    output logic [2:0]       o_crc_err_fifo_data4_crc_rpt_num_next,
    output logic [15:0]      o_crc_err_fifo_data4_crc_req_id_next,
    output logic             o_crc_err_fifo_pop_valid_wr_enable,
    output logic             o_crc_err_rsp_full_int_lvl,
    output logic [LVL_W-1:0] o_level,
    output logic [7:0]       o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0]  code;
        logic [63:0] poly;
        logic [31:0] data_addr;
        logic [31:0] crc_addr;
        logic [1:0]  size_sel;
        logic [2:0]  rpt_num;
        logic [15:0] req_id;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_POP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    entry_t             mem [DEPTH];
    entry_t             head_reg;
    entry_t             entry_in;
    logic [PTR_W-1:0]   wptr_reg, rptr_reg;
    logic [LVL_W-1:0]   count_reg;
    logic               pop_q_reg;
    logic [7:0]         drop_cnt_reg;
    logic               pop_edge, dequeue, fifo_full, push_ok, drop;

    assign entry_in = '{code: i_err_rsp_code, poly: i_poly, data_addr: i_data_addr,
                        crc_addr: i_crc_addr, size_sel: i_poly_size_sel,
                        rpt_num: i_rpt_num, req_id: i_req_id};

    assign pop_edge  = i_pop & ~pop_q_reg;
    assign fifo_full = (count_reg == LVL_W'(DEPTH));
    // A dequeue in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok   = i_push & (~fifo_full | dequeue);
    assign drop      = i_push & fifo_full & ~dequeue;

    always_comb begin
        state_next = state_reg;
        dequeue    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    dequeue    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD:     state_next = WAIT_POP;
            WAIT_POP: if (pop_edge) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            state_reg <= IDLE;
            pop_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pop_q_reg <= i_pop;
        end
    end

    // Storage array has no reset; the count alone decides which slots are live.
    always_ff @(posedge i_sys_clk) begin
        if (push_ok) mem[wptr_reg] <= entry_in;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
            head_reg     <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + PTR_W'(1);
            if (dequeue) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
                head_reg <= mem[rptr_reg];
            end
            case ({push_ok, dequeue})
                2'b10:   count_reg <= count_reg + LVL_W'(1);
                2'b01:   count_reg <= count_reg - LVL_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign o_crc_err_fifo_pop_err_rsp_code_next        = head_reg.code;
    assign o_crc_err_fifo_data0_poly_lsb_next          = head_reg.poly[31:0];
    assign o_crc_err_fifo_data1_poly_msb_next          = head_reg.poly[63:32];
    assign o_crc_err_fifo_data2_data_addr_next         = head_reg.data_addr;
    assign o_crc_err_fifo_data3_crc_addr_next          = head_reg.crc_addr;
    assign o_crc_err_fifo_data4_crc_poly_size_sel_next = head_reg.size_sel;
    assign o_crc_err_fifo_data4_crc_rpt_num_next       = head_reg.rpt_num;
    assign o_crc_err_fifo_data4_crc_req_id_next        = head_reg.req_id;
    assign o_crc_err_fifo_pop_valid_wr_enable          = (state_reg == LOAD);
    assign o_crc_err_rsp_full_int_lvl                  = fifo_full;
    assign o_level                                     = count_reg;
    assign o_drop_cnt                                  = drop_cnt_reg;

endmodule

// File: tb/tb_crc_err_rsp_fifo.sv
// Randomized bench for crc_err_rsp_fifo: a queue-level model predicts shown entries,
// level, full and drops; a negedge monitor checks every load strobe against a scoreboard.
module tb_crc_err_rsp_fifo;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0]  code;
        logic [63:0] poly;
        logic [31:0] data_addr;
        logic [31:0] crc_addr;
        logic [1:0]  size_sel;
        logic [2:0]  rpt_num;
        logic [15:0] req_id;
    } entry_t;

    logic clk, rst, i_push, i_pop;
    entry_t din;
    logic [7:0]  code_o;
    logic [31:0] d0_o, d1_o, d2_o, d3_o;
    logic [1:0]  size_o;
    logic [2:0]  rpt_o;
    logic [15:0] id_o;
    logic        wr_o, full_o;
    logic [LVL_W-1:0] level_o;
    logic [7:0]  drop_o;
    entry_t      head_o;

    crc_err_rsp_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .i_sys_clk(clk),
        .i_sys_arst(rst),
        .i_push(i_push),
        .i_err_rsp_code(din.code),
        .i_poly(din.poly),
        .i_data_addr(din.data_addr),
        .i_crc_addr(din.crc_addr),
        .i_poly_size_sel(din.size_sel),
        .i_rpt_num(din.rpt_num),
        .i_req_id(din.req_id),
        .i_pop(i_pop),
        .o_crc_err_fifo_pop_err_rsp_code_next(code_o),
        .o_crc_err_fifo_data0_poly_lsb_next(d0_o),
        .o_crc_err_fifo_data1_poly_msb_next(d1_o),
        .o_crc_err_fifo_data2_data_addr_next(d2_o),
        .o_crc_err_fifo_data3_crc_addr_next(d3_o),
        .o_crc_err_fifo_data4_crc_poly_size_sel_next(size_o),
        .o_crc_err_fifo_data4_crc_rpt_num_next(rpt_o),
        .o_crc_err_fifo_data4_crc_req_id_next(id_o),
        .o_crc_err_fifo_pop_valid_wr_enable(wr_o),
        .o_crc_err_rsp_full_int_lvl(full_o),
        .o_level(level_o),
        .o_drop_cnt(drop_o)
    );

    assign head_o = '{code: code_o, poly: {d1_o, d0_o}, data_addr: d2_o, crc_addr: d3_o,
                      size_sel: size_o, rpt_num: rpt_o, req_id: id_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [156:0] act, input logic [156:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored queue, a display slot that must be acknowledged
    // by a POP rising edge arriving after its load strobe, and a saturating drop tally.
    entry_t mq[$];
    entry_t sb[$];
    entry_t shown;
    bit     busy, exp_wr, prev_pop, pe;
    int     age, m_drop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            shown    = '0;
            busy     = 1'b0;
            exp_wr   = 1'b0;
            prev_pop = 1'b0;
            age      = 0;
            m_drop   = 0;
        end else begin
            pe       = i_pop && !prev_pop;
            prev_pop = i_pop;
            exp_wr   = 1'b0;
            if (!busy) begin
                if (mq.size() > 0) begin
                    shown  = mq.pop_front();
                    sb.push_back(shown);
                    busy   = 1'b1;
                    age    = 0;
                    exp_wr = 1'b1;
                end
            end else if (pe && age >= 1) begin
                busy = 1'b0;
            end else begin
                age++;
            end
            if (i_push) begin
                if (mq.size() < DEPTH) mq.push_back(din);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        entry_t exp_e;
        if (!rst) begin
            check("wr_enable", wr_o, exp_wr);
            check("level", level_o, mq.size());
            check("full_lvl", full_o, mq.size() == DEPTH);
            check("drop_cnt", drop_o, m_drop);
            check("shown_data", head_o, shown);
            if (wr_o) begin
                if (sb.size() == 0) begin
                    check("strobe_unexpected", 1, 0);
                end else begin
                    exp_e = sb.pop_front();
                    check("popped_entry", head_o, exp_e);
                    $display("load code=%h req_id=%h poly=%h level=%0d", code_o, id_o,
                             {d1_o, d0_o}, level_o);
                end
            end
        end
    end

    function automatic entry_t rand_entry();
        entry_t e;
        e.code      = 8'($urandom);
        e.poly      = {$urandom, $urandom};
        e.data_addr = $urandom;
        e.crc_addr  = $urandom;
        e.size_sel  = 2'($urandom);
        e.rpt_num   = 3'($urandom);
        e.req_id    = 16'($urandom);
        return e;
    endfunction

    task automatic drive(input bit p, input entry_t e, input bit pp);
        @(negedge clk);
        i_push = p;
        din    = e;
        i_pop  = pp;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic pop_pulse();
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic check_all_zero();
        check("rst_data", head_o, 0);
        check("rst_wr_enable", wr_o, 0);
        check("rst_full_lvl", full_o, 0);
        check("rst_level", level_o, 0);
        check("rst_drop_cnt", drop_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_push = 1'b0;
        i_pop  = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (mq.size() != 0 || busy); k++) begin
            pop_pulse();
            idle(2);
        end
        check("drain_done", mq.size() + busy, 0);
    endtask

    initial begin
        entry_t e;
        rst = 1'b1; i_push = 1'b0; i_pop = 1'b0; din = '0;
        #1 check_all_zero();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Single push with known fields.
        e = rand_entry();
        e.code = 8'h5A; e.poly = 64'h1122334455667788; e.req_id = 16'h0042;
        drive(1'b1, e, 1'b0);
        idle(4);
        check("single_poly_msb", d1_o, 32'h11223344);
        check("single_poly_lsb", d0_o, 32'h55667788);
        pop_pulse(); idle(2);

        // Three back-to-back pushes; long POP level advances only once.
        for (int k = 0; k < 3; k++) drive(1'b1, rand_entry(), 1'b0);
        idle(3);
        for (int k = 0; k < 5; k++) drive(1'b0, '0, 1'b1);
        idle(4);
        drain();

        // Fill to full with one shown, then overflow by three.
        for (int k = 0; k < DEPTH + 1; k++) drive(1'b1, rand_entry(), 1'b0);
        idle(3);
        check("full_after_fill", full_o, 1);
        for (int k = 0; k < 3; k++) drive(1'b1, rand_entry(), 1'b0);
        idle(2);
        check("drop_three", drop_o, 3);
        pop_pulse(); idle(3);

        // Back to full, then push in the dequeue cycle.
        drive(1'b1, rand_entry(), 1'b0);
        idle(2);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, rand_entry(), 1'b0);
        idle(3);
        check("coincident_level", level_o, DEPTH);
        drain();
        pop_pulse(); idle(2);

        // POP edges while IDLE and LOAD must be ignored.
        drive(1'b1, rand_entry(), 1'b1);
        drive(1'b1, rand_entry(), 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        idle(4);

        // Reset in WAIT_POP with four stored entries.
        for (int k = 0; k < 3; k++) drive(1'b1, rand_entry(), 1'b0);
        idle(2);
        do_reset();
        idle(1);
        drive(1'b1, rand_entry(), 1'b0);
        idle(4);

        // Saturate the drop counter.
        for (int k = 0; k < DEPTH + 262; k++) drive(1'b1, rand_entry(), 1'b0);
        idle(2);
        check("drop_saturated", drop_o, 255);
        do_reset();

        // Random traffic well beyond several pointer wraps.
        for (int k = 0; k < 400; k++)
            drive($urandom_range(0, 99) < 45, rand_entry(), $urandom_range(0, 99) < 35);
        drain();
        idle(3);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_err_rsp_fifo.md
# crc_err_rsp_fifo

Buffers error responses from the CRC engine and presents them one at a time to the CRC register wrapper's ERR_FIFO_POP / ERR_FIFO_DATA0..4 registers. Firmware consumes each entry by writing POP, which advances the queue. Sits between the CRC engine's response path (upstream) and `crc_reg_wrap` (downstream). Also drives the full-level interrupt source and an overflow drop counter.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- LVL_W, $clog2(DEPTH+1), width of the level output.

Ports (one clock; reset is asynchronous and active-high):
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_arst  in  1  asynchronous active-high reset.
- i_push  in  1  one-cycle strobe: an error response is valid on the i_* fields.
- i_err_rsp_code  in  8  response code.
- i_poly  in  64  polynomial used.
- i_data_addr  in  32  data address.
- i_crc_addr  in  32  CRC address.
- i_poly_size_sel  in  2  polynomial size select.
- i_rpt_num  in  3  repeat number.
- i_req_id  in  16  request ID.
- i_pop  in  1  ERR_FIFO_POP.POP field level, from the register block.
- o_crc_err_fifo_pop_err_rsp_code_next  out  8  head entry code.
- o_crc_err_fifo_data0_poly_lsb_next  out  32  i_poly[31:0] of the head entry.
- o_crc_err_fifo_data1_poly_msb_next  out  32  i_poly[63:32] of the head entry.
- o_crc_err_fifo_data2_data_addr_next  out  32  head entry data address.
- o_crc_err_fifo_data3_crc_addr_next  out  32  head entry CRC address.
- o_crc_err_fifo_data4_crc_poly_size_sel_next  out  2  head entry size select.
- o_crc_err_fifo_data4_crc_rpt_num_next  out  3  head entry repeat number.
- o_crc_err_fifo_data4_crc_req_id_next  out  16  head entry request ID.
- o_crc_err_fifo_pop_valid_wr_enable  out  1  one-cycle load strobe to all ERR_FIFO registers.
- o_crc_err_rsp_full_int_lvl  out  1  high while the FIFO holds DEPTH entries.
- o_level  out  LVL_W  entries currently stored. Excludes the entry shown in the registers.
- o_drop_cnt  out  8  count of dropped pushes; saturates at 255; cleared only by reset.

## Operation
- Storage: circular buffer of DEPTH × 157-bit entries, with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push: if i_push and (count < DEPTH, or a dequeue happens in the same cycle), write at wptr and advance wptr.
- Drop: if i_push, count == DEPTH and no same-cycle dequeue, the entry is discarded and o_drop_cnt increments (saturating at 255).
- Count update: +1 on an accepted push only, −1 on a dequeue only, unchanged when both occur.
- Pop edge: pop_q is a registered copy of i_pop; pop_edge = i_pop & ~pop_q. The length of the POP level is irrelevant.
- State machine (2-bit):
  - IDLE: if count != 0, dequeue the head into the output registers, advance rptr, go to LOAD.
  - LOAD: o_crc_err_fifo_pop_valid_wr_enable = 1 for exactly this cycle; go to WAIT_POP.
  - WAIT_POP: on pop_edge, go to IDLE; otherwise stay.
- pop_edge in IDLE or LOAD is ignored, and pop_q still updates.
- Output data registers are loaded only on the IDLE→LOAD transition and hold until the next load.
- Clearing the VALID bit is owned by the register block, not by this block.
- o_crc_err_rsp_full_int_lvl = (count == DEPTH), combinational from the count register. The register block edge-detects it.

## Timing
- Reset (asynchronous, effective immediately): state IDLE, pointers and count 0, pop_q 0, o_drop_cnt 0, all data outputs 0, wr_enable 0, full_lvl 0, o_level 0.
- Reset asserted mid-operation: all stored and shown entries are lost, with no wr_enable glitch.
- Push sampled at edge E0 into an empty FIFO in IDLE: count = 1 after E0. At E1, dequeue, state LOAD, data valid. wr_enable is high between E1 and E2, and the register block captures at E2.
- pop_edge sampled at edge P in WAIT_POP: IDLE after P; if count != 0, LOAD after P+1. Pop-to-next-strobe latency is 2 cycles.
- Push and dequeue in the same cycle with count == DEPTH: the push is accepted, count stays DEPTH, no drop.
- o_level and full_lvl reflect the count register, one cycle after the causing edge.

## Test plan
- Reset, single push (code 0x5A, poly 0x1122334455667788, req_id 0x0042) → wr_enable high for exactly 1 cycle, 2 cycles after the push; data1 = 0x11223344, data0 = 0x55667788; o_level = 0.
- Push 3 entries back-to-back → only entry 0 is loaded. Raising i_pop and holding it 5 cycles → exactly one new load, of entry 1. Entries emerge in FIFO order.
- Fill DEPTH+1 entries with one already shown (8 stored) → full_lvl = 1. Push 3 more → o_drop_cnt = 3, o_level = 8. One pop → full_lvl deasserts the cycle after the dequeue.
- With count = 8, push coincident with a dequeue (pop_edge → IDLE) → no drop, o_level stays 8, and the new entry is at the tail.
- Pulse i_pop while in IDLE/LOAD → ignored. Assert i_sys_arst while in WAIT_POP with 4 entries stored → all outputs 0 immediately. After release, one push → normal load.
- Force 260 drops → o_drop_cnt saturates at 255. Pointer wrap across 3×DEPTH push/pop cycles preserves the data.
